// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: state encodings,
// the bundled control word and the register-match helper.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MEMW = 2'd1,
    DIVW = 2'd2,
    EXC  = 2'd3
  } hz_state_t;

  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_wen;
    logic id_ex_flush;
    logic id_ex_bp_flush;
    logic ex_mem_wen;
    logic ex_mem_flush;
    logic div_cancel;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_OFF      = hz_ctrl_t'(9'b0_0_0_0_0_0_0_0_0);
  localparam hz_ctrl_t CTRL_RUN      = hz_ctrl_t'(9'b1_1_0_1_0_0_1_0_0);
  localparam hz_ctrl_t CTRL_LOAD_USE = hz_ctrl_t'(9'b0_0_0_1_1_0_1_0_0);
  localparam hz_ctrl_t CTRL_MISPRED  = hz_ctrl_t'(9'b1_1_1_1_1_1_1_0_0);
  localparam hz_ctrl_t CTRL_DIV_WAIT = hz_ctrl_t'(9'b0_0_0_0_0_0_1_1_0);
  localparam hz_ctrl_t CTRL_DIV_DONE = hz_ctrl_t'(9'b0_0_0_0_0_0_1_0_0);
  localparam hz_ctrl_t CTRL_REDIRECT = hz_ctrl_t'(9'b1_1_1_1_1_1_1_1_0);
  localparam hz_ctrl_t CTRL_EXC_HOLD = hz_ctrl_t'(9'b0_1_1_1_1_1_1_1_0);

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  function automatic logic reg_hit(input logic [4:0] ex_d, input logic [4:0] id_r,
                                   input logic ren);
    return ren && (id_r == ex_d);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the destination
// of a load currently in EX. r0 never creates a hazard.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_reg_d,
  input  logic [4:0] id_reg_j,
  input  logic [4:0] id_reg_k,
  input  logic [4:0] id_reg_d,
  input  logic       id_reg_j_ren,
  input  logic       id_reg_k_ren,
  input  logic       id_reg_d_ren,
  output logic       hazard
);

  logic any_hit;

  assign any_hit = reg_hit(ex_reg_d, id_reg_j, id_reg_j_ren)
                || reg_hit(ex_reg_d, id_reg_k, id_reg_k_ren)
                || reg_hit(ex_reg_d, id_reg_d, id_reg_d_ren);

  assign hazard = ex_valid && ex_is_load && (ex_reg_d != 5'd0) && any_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sole source of stage-register wen/flush and pc_wen.
// state | meaning
// RUN   | normal flow; resolves exception, mispredict, mem wait, divide start, load-use
// MEMW  | data-RAM wait; behaves exactly like RUN (mem_busy freezes, falling edge resumes)
// DIVW  | multi-cycle divide in flight; upstream frozen, bubbles into MEM
// EXC   | exception drain; every stage flushed for EXC_HOLD cycles
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned DIV_MAX_CYCLES = 33,
  parameter int unsigned EXC_HOLD       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_reg_j,
  input  logic [4:0]  id_reg_k,
  input  logic [4:0]  id_reg_d,
  input  logic        id_reg_j_ren,
  input  logic        id_reg_k_ren,
  input  logic        id_reg_d_ren,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_reg_d,
  input  logic        ex_div_start,
  input  logic        ex_div_done,
  input  logic        ex_mispredict,
  input  logic        mem_busy,
  input  logic        wb_exception,
  output logic        pc_wen,
  output logic        if_id_wen,
  output logic        if_id_flush,
  output logic        id_ex_wen,
  output logic        id_ex_flush,
  output logic        id_ex_bp_flush,
  output logic        ex_mem_wen,
  output logic        ex_mem_flush,
  output logic        div_cancel,
  output logic        div_timeout_err,
  output logic [31:0] stall_cnt
);

  localparam logic [7:0] DIV_LAST = 8'(DIV_MAX_CYCLES - 1);
  localparam logic [3:0] EXC_LOAD = 4'(EXC_HOLD - 1);
  localparam hz_state_t  EXC_NEXT = (EXC_HOLD > 1) ? EXC : RUN;

  hz_state_t  state;
  logic [7:0] div_cnt;
  logic [3:0] exc_cnt;
  logic       lu_hazard;
  hz_ctrl_t   ctrl;

  load_use_detect u_load_use (
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_reg_d     (ex_reg_d),
    .id_reg_j     (id_reg_j),
    .id_reg_k     (id_reg_k),
    .id_reg_d     (id_reg_d),
    .id_reg_j_ren (id_reg_j_ren),
    .id_reg_k_ren (id_reg_k_ren),
    .id_reg_d_ren (id_reg_d_ren),
    .hazard       (lu_hazard)
  );

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst) begin
      ctrl = CTRL_OFF;
    end else begin
      case (state)
        RUN, MEMW: begin
          if (wb_exception)       ctrl = CTRL_REDIRECT;
          else if (ex_mispredict) ctrl = CTRL_MISPRED;
          else if (mem_busy)      ctrl = CTRL_OFF;
          else if (ex_div_start)  ctrl = CTRL_DIV_WAIT;
          else if (lu_hazard)     ctrl = CTRL_LOAD_USE;
        end
        DIVW: begin
          if (wb_exception) begin
            ctrl            = CTRL_REDIRECT;
            ctrl.div_cancel = 1'b1;
          end else if (ex_div_done) begin
            ctrl = CTRL_DIV_DONE;
          end else if (div_cnt == DIV_LAST) begin
            ctrl            = CTRL_DIV_WAIT;
            ctrl.div_cancel = 1'b1;
          end else begin
            ctrl = CTRL_DIV_WAIT;
          end
        end
        EXC: begin
          ctrl = wb_exception ? CTRL_REDIRECT : CTRL_EXC_HOLD;
        end
      endcase
    end
  end

  assign pc_wen         = ctrl.pc_wen;
  assign if_id_wen      = ctrl.if_id_wen;
  assign if_id_flush    = ctrl.if_id_flush;
  assign id_ex_wen      = ctrl.id_ex_wen;
  assign id_ex_flush    = ctrl.id_ex_flush;
  assign id_ex_bp_flush = ctrl.id_ex_bp_flush;
  assign ex_mem_wen     = ctrl.ex_mem_wen;
  assign ex_mem_flush   = ctrl.ex_mem_flush;
  assign div_cancel     = ctrl.div_cancel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      div_cnt         <= '0;
      exc_cnt         <= '0;
      div_timeout_err <= 1'b0;
      stall_cnt       <= '0;
    end else begin
      if (!ctrl.pc_wen && (stall_cnt != STALL_MAX)) stall_cnt <= stall_cnt + 32'd1;
      case (state)
        RUN, MEMW: begin
          if (wb_exception) begin
            exc_cnt <= EXC_LOAD;
            state   <= EXC_NEXT;
          end else if (ex_mispredict) begin
            state <= RUN;
          end else if (mem_busy) begin
            state <= MEMW;
          end else if (ex_div_start) begin
            div_cnt <= '0;
            state   <= DIVW;
          end else begin
            state <= RUN;
          end
        end
        DIVW: begin
          div_cnt <= div_cnt + 8'd1;
          if (wb_exception) begin
            exc_cnt <= EXC_LOAD;
            state   <= EXC_NEXT;
          end else if (ex_div_done) begin
            state <= RUN;
          end else if (div_cnt == DIV_LAST) begin
            div_timeout_err <= 1'b1;
            state           <= RUN;
          end
        end
        EXC: begin
          if (wb_exception) begin
            exc_cnt <= EXC_LOAD;
            state   <= EXC_NEXT;
          end else if (exc_cnt == 4'd0) begin
            state <= RUN;
          end else begin
            exc_cnt <= exc_cnt - 4'd1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a default instance (33-cycle divide
// watchdog) and a short-watchdog instance share all inputs.
module tb_pipe_hazard_ctrl;

  // Control word bit order:
  // pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, id_ex_bp_flush, ex_mem_wen, ex_mem_flush, div_cancel
  localparam logic [8:0] E_OFF    = 9'b000000000;
  localparam logic [8:0] E_RUN    = 9'b110100100;
  localparam logic [8:0] E_LU     = 9'b000110100;
  localparam logic [8:0] E_MISP   = 9'b111111100;
  localparam logic [8:0] E_FREEZE = 9'b000000000;
  localparam logic [8:0] E_DIVW   = 9'b000000110;
  localparam logic [8:0] E_DIVD   = 9'b000000100;
  localparam logic [8:0] E_DIVTO  = 9'b000000111;
  localparam logic [8:0] E_EXCR   = 9'b111111110;
  localparam logic [8:0] E_EXCRC  = 9'b111111111;
  localparam logic [8:0] E_EXCH   = 9'b011111110;

  // event bits: {wb_exception, ex_mispredict, mem_busy, ex_div_start, ex_div_done, load in EX}
  localparam logic [5:0] EV_NONE = 6'b000000;
  localparam logic [5:0] EV_EXC  = 6'b100000;
  localparam logic [5:0] EV_MP   = 6'b010000;
  localparam logic [5:0] EV_BUSY = 6'b001000;
  localparam logic [5:0] EV_DS   = 6'b000100;
  localparam logic [5:0] EV_DD   = 6'b000010;
  localparam logic [5:0] EV_LD   = 6'b000001;

  typedef struct {
    string      tag;
    logic [8:0] e;
    logic [5:0] ev;
    logic [4:0] exd, rj, rk, rd;
    logic [2:0] ren;
  } step_t;

  logic        clk, rst;
  logic [4:0]  id_reg_j, id_reg_k, id_reg_d, ex_reg_d;
  logic        id_reg_j_ren, id_reg_k_ren, id_reg_d_ren;
  logic        ex_valid, ex_is_load, ex_div_start, ex_div_done, ex_mispredict, mem_busy, wb_exception;

  logic        pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, id_ex_bp_flush;
  logic        ex_mem_wen, ex_mem_flush, div_cancel, div_timeout_err;
  logic [31:0] stall_cnt;
  logic        pc_wen_4, if_id_wen_4, if_id_flush_4, id_ex_wen_4, id_ex_flush_4, id_ex_bp_flush_4;
  logic        ex_mem_wen_4, ex_mem_flush_4, div_cancel_4, div_timeout_err_4;
  logic [31:0] stall_cnt_4;

  logic [8:0]  ctrl, ctrl4;
  int          checks, errors;
  int unsigned exp_stall;
  step_t       sb[$];

  assign ctrl  = {pc_wen, if_id_wen, if_id_flush, id_ex_wen, id_ex_flush, id_ex_bp_flush,
                  ex_mem_wen, ex_mem_flush, div_cancel};
  assign ctrl4 = {pc_wen_4, if_id_wen_4, if_id_flush_4, id_ex_wen_4, id_ex_flush_4, id_ex_bp_flush_4,
                  ex_mem_wen_4, ex_mem_flush_4, div_cancel_4};

  pipe_hazard_ctrl #(.DIV_MAX_CYCLES(33), .EXC_HOLD(2)) dut (
    .clk(clk), .rst(rst),
    .id_reg_j(id_reg_j), .id_reg_k(id_reg_k), .id_reg_d(id_reg_d),
    .id_reg_j_ren(id_reg_j_ren), .id_reg_k_ren(id_reg_k_ren), .id_reg_d_ren(id_reg_d_ren),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_d(ex_reg_d),
    .ex_div_start(ex_div_start), .ex_div_done(ex_div_done), .ex_mispredict(ex_mispredict),
    .mem_busy(mem_busy), .wb_exception(wb_exception),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .if_id_flush(if_id_flush),
    .id_ex_wen(id_ex_wen), .id_ex_flush(id_ex_flush), .id_ex_bp_flush(id_ex_bp_flush),
    .ex_mem_wen(ex_mem_wen), .ex_mem_flush(ex_mem_flush), .div_cancel(div_cancel),
    .div_timeout_err(div_timeout_err), .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.DIV_MAX_CYCLES(4), .EXC_HOLD(2)) dut4 (
    .clk(clk), .rst(rst),
    .id_reg_j(id_reg_j), .id_reg_k(id_reg_k), .id_reg_d(id_reg_d),
    .id_reg_j_ren(id_reg_j_ren), .id_reg_k_ren(id_reg_k_ren), .id_reg_d_ren(id_reg_d_ren),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_reg_d(ex_reg_d),
    .ex_div_start(ex_div_start), .ex_div_done(ex_div_done), .ex_mispredict(ex_mispredict),
    .mem_busy(mem_busy), .wb_exception(wb_exception),
    .pc_wen(pc_wen_4), .if_id_wen(if_id_wen_4), .if_id_flush(if_id_flush_4),
    .id_ex_wen(id_ex_wen_4), .id_ex_flush(id_ex_flush_4), .id_ex_bp_flush(id_ex_bp_flush_4),
    .ex_mem_wen(ex_mem_wen_4), .ex_mem_flush(ex_mem_flush_4), .div_cancel(div_cancel_4),
    .div_timeout_err(div_timeout_err_4), .stall_cnt(stall_cnt_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic step_t mk(string tag, logic [8:0] e, logic [5:0] ev,
                               logic [4:0] exd = 5'd0, logic [4:0] rj = 5'd0,
                               logic [4:0] rk = 5'd0, logic [4:0] rd = 5'd0,
                               logic [2:0] ren = 3'b000);
    step_t s;
    s.tag = tag; s.e = e; s.ev = ev;
    s.exd = exd; s.rj = rj; s.rk = rk; s.rd = rd; s.ren = ren;
    return s;
  endfunction

  task automatic apply(input step_t s);
    wb_exception  = s.ev[5];
    ex_mispredict = s.ev[4];
    mem_busy      = s.ev[3];
    ex_div_start  = s.ev[2];
    ex_div_done   = s.ev[1];
    ex_valid      = s.ev[0];
    ex_is_load    = s.ev[0];
    ex_reg_d      = s.exd;
    id_reg_j      = s.rj;
    id_reg_k      = s.rk;
    id_reg_d      = s.rd;
    id_reg_j_ren  = s.ren[2];
    id_reg_k_ren  = s.ren[1];
    id_reg_d_ren  = s.ren[0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(mk("idle", E_OFF, EV_NONE));
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
  endtask

  task automatic test_reset();
    step_t got;
    rst = 1'b1;
    apply(mk("idle", E_OFF, EV_NONE));
    @(negedge clk);
    checks++;
    if (ctrl !== E_OFF) begin errors++; $display("FAIL reset_ctrl: ctrl=%b expected %b", ctrl, E_OFF); end
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall: stall_cnt=%0d expected 0", stall_cnt); end
    checks++;
    if (div_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err: div_timeout_err=%b expected 0", div_timeout_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
    sb.push_back(mk("run_default", E_RUN, EV_NONE));
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    step_t tbl[$];
    step_t got;
    tbl.push_back(mk("lu_j",     E_LU,  EV_LD,   5'd5, 5'd5, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("lu_after", E_RUN, EV_NONE, 5'd5, 5'd5, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("lu_r0",    E_RUN, EV_LD,   5'd5, 5'd0, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("lu_r6",    E_RUN, EV_LD,   5'd5, 5'd6, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("lu_k",     E_LU,  EV_LD,   5'd5, 5'd0, 5'd5, 5'd0, 3'b010));
    tbl.push_back(mk("lu_d",     E_LU,  EV_LD,   5'd17, 5'd3, 5'd9, 5'd17, 3'b111));
    tbl.push_back(mk("lu_noren", E_RUN, EV_LD,   5'd5, 5'd5, 5'd5, 5'd5, 3'b000));
    tbl.push_back(mk("lu_exd0",  E_RUN, EV_LD,   5'd0, 5'd0, 5'd0, 5'd0, 3'b111));
    tbl.push_back(mk("lu_noload", E_RUN, EV_NONE, 5'd5, 5'd5, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("lu_hibit", E_RUN, EV_LD,   5'd21, 5'd5, 5'd0, 5'd0, 3'b100));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
      if (!got.e[8]) exp_stall++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL lu_stall_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_mispredict();
    step_t tbl[$];
    step_t got;
    tbl.push_back(mk("mp_with_lu", E_MISP, EV_MP | EV_LD, 5'd5, 5'd5, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("mp_after",   E_RUN,  EV_NONE));
    tbl.push_back(mk("mp_over_busy", E_MISP, EV_MP | EV_BUSY));
    tbl.push_back(mk("mp_over_div",  E_MISP, EV_MP | EV_DS));
    tbl.push_back(mk("mp_idle",    E_RUN,  EV_NONE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
      if (!got.e[8]) exp_stall++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL mp_stall_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_div_done();
    step_t tbl[$];
    step_t got;
    tbl.push_back(mk("div_start", E_DIVW, EV_DS));
    for (int n = 1; n <= 9; n++) tbl.push_back(mk($sformatf("div_wait%0d", n), E_DIVW, EV_NONE));
    tbl.push_back(mk("div_done",  E_DIVD, EV_DD));
    tbl.push_back(mk("div_after", E_RUN,  EV_NONE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
      if (!got.e[8]) exp_stall++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL div_stall_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_stall); end
    checks++;
    if (div_timeout_err !== 1'b0) begin errors++; $display("FAIL div_no_timeout: div_timeout_err=%b expected 0", div_timeout_err); end
  endtask

  task automatic test_div_timeout();
    step_t tbl[$];
    step_t got;
    do_reset();
    // done on the last watchdog cycle beats the timeout
    tbl.push_back(mk("to4_edge_start", E_DIVW, EV_DS));
    tbl.push_back(mk("to4_edge_w1",    E_DIVW, EV_NONE));
    tbl.push_back(mk("to4_edge_w2",    E_DIVW, EV_NONE));
    tbl.push_back(mk("to4_edge_w3",    E_DIVW, EV_NONE));
    tbl.push_back(mk("to4_edge_done",  E_DIVD, EV_DD));
    tbl.push_back(mk("to4_start",      E_DIVW, EV_DS));
    tbl.push_back(mk("to4_w1",         E_DIVW, EV_NONE));
    tbl.push_back(mk("to4_w2",         E_DIVW, EV_NONE));
    tbl.push_back(mk("to4_w3",         E_DIVW, EV_NONE));
    tbl.push_back(mk("to4_cancel",     E_DIVTO, EV_NONE));
    tbl.push_back(mk("to4_after",      E_RUN,  EV_NONE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl4 !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl4, got.e); end
      if (i == 4) begin
        checks++;
        if (div_timeout_err_4 !== 1'b0) begin errors++; $display("FAIL to4_edge_err: div_timeout_err=%b expected 0", div_timeout_err_4); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (div_timeout_err_4 !== 1'b1) begin errors++; $display("FAIL to4_err_set: div_timeout_err=%b expected 1", div_timeout_err_4); end
    for (int n = 0; n < 5; n++) begin
      apply(mk("idle", E_RUN, EV_NONE));
      @(posedge clk); #1;
    end
    checks++;
    if (div_timeout_err_4 !== 1'b1) begin errors++; $display("FAIL to4_err_sticky: div_timeout_err=%b expected 1", div_timeout_err_4); end
    checks++;
    if (div_timeout_err !== 1'b0) begin errors++; $display("FAIL to33_no_err: div_timeout_err=%b expected 0", div_timeout_err); end
  endtask

  task automatic test_reset_mid_div();
    step_t tbl[$];
    step_t got;
    do_reset();
    tbl.push_back(mk("rd_start", E_DIVW, EV_DS));
    tbl.push_back(mk("rd_w1",    E_DIVW, EV_NONE));
    tbl.push_back(mk("rd_w2",    E_DIVW, EV_NONE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl !== E_OFF) begin errors++; $display("FAIL rd_rst_ctrl: ctrl=%b expected %b", ctrl, E_OFF); end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rd_rst_stall: stall_cnt=%0d expected 0", stall_cnt); end
    @(negedge clk);
    checks++;
    if (ctrl !== E_OFF) begin errors++; $display("FAIL rd_rst_ctrl2: ctrl=%b expected %b", ctrl, E_OFF); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 0;
    @(negedge clk);
    checks++;
    if (ctrl !== E_RUN) begin errors++; $display("FAIL rd_back_to_run: ctrl=%b expected %b", ctrl, E_RUN); end
    @(posedge clk); #1;
  endtask

  task automatic test_mem_exception();
    step_t tbl[$];
    step_t got;
    do_reset();
    // also run the reset-cleared sticky bit check on the short-watchdog copy
    checks++;
    if (div_timeout_err_4 !== 1'b0) begin errors++; $display("FAIL rst_clears_err: div_timeout_err=%b expected 0", div_timeout_err_4); end
    tbl.push_back(mk("mx_freeze", E_FREEZE, EV_BUSY));
    tbl.push_back(mk("mx_exc",    E_EXCR,   EV_BUSY | EV_EXC));
    tbl.push_back(mk("mx_hold1",  E_EXCH,   EV_BUSY));
    tbl.push_back(mk("mx_hold2",  E_EXCH,   EV_NONE));
    tbl.push_back(mk("mx_run",    E_RUN,    EV_NONE));
    tbl.push_back(mk("mx_div",    E_DIVW,   EV_DS));
    tbl.push_back(mk("mx_divw",   E_DIVW,   EV_NONE));
    tbl.push_back(mk("mx_div_exc", E_EXCRC, EV_EXC | EV_DD));
    tbl.push_back(mk("mx_dh1",    E_EXCH,   EV_NONE));
    tbl.push_back(mk("mx_dh2",    E_EXCH,   EV_NONE));
    tbl.push_back(mk("mx_drun",   E_RUN,    EV_NONE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
      if (!got.e[8]) exp_stall++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL mx_stall_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_back_to_back();
    step_t tbl[$];
    step_t got;
    tbl.push_back(mk("bb_exc_mp",  E_EXCR,   EV_EXC | EV_MP));
    tbl.push_back(mk("bb_hold",    E_EXCH,   EV_NONE));
    tbl.push_back(mk("bb_reexc",   E_EXCR,   EV_EXC));
    tbl.push_back(mk("bb_hold1",   E_EXCH,   EV_MP));
    tbl.push_back(mk("bb_hold2",   E_EXCH,   EV_NONE));
    tbl.push_back(mk("bb_run",     E_RUN,    EV_NONE));
    tbl.push_back(mk("bb_busy_ds", E_FREEZE, EV_BUSY | EV_DS));
    tbl.push_back(mk("bb_ds",      E_DIVW,   EV_DS));
    tbl.push_back(mk("bb_dd",      E_DIVD,   EV_DD));
    tbl.push_back(mk("bb_lu",      E_LU,     EV_LD, 5'd31, 5'd31, 5'd0, 5'd0, 3'b100));
    tbl.push_back(mk("bb_idle",    E_RUN,    EV_NONE));
    foreach (tbl[i]) begin
      apply(tbl[i]);
      sb.push_back(tbl[i]);
      @(negedge clk);
      got = sb.pop_front();
      checks++;
      if (ctrl !== got.e) begin errors++; $display("FAIL %s: ctrl=%b expected %b", got.tag, ctrl, got.e); end
      if (!got.e[8]) exp_stall++;
      @(posedge clk); #1;
    end
    checks++;
    if (stall_cnt !== 32'(exp_stall)) begin errors++; $display("FAIL bb_stall_cnt: stall_cnt=%0d expected %0d", stall_cnt, exp_stall); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    rst = 1'b1;
    apply(mk("idle", E_OFF, EV_NONE));
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_mispredict();
    test_div_done();
    test_div_timeout();
    test_reset_mid_div();
    test_mem_exception();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
